// File: rtl/cvw_pkg.sv
// cvw_pkg: interrupt bit indices, architected-interrupt mask and WFI FSM state encoding
package cvw_pkg;
   localparam int MEI = 11, SEI = 9, MTI = 7, STI = 5, MSI = 3, SSI = 1;
   localparam logic [11:0] INT_MASK = 12'hAAA;
   typedef enum logic [1:0] {RUN, WFI, WAKE} wfistate_t;
endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: picks the highest-priority qualified interrupt (MEI, MSI, MTI, SEI, SSI, STI)
module int_prio_enc
   import cvw_pkg::*;
(
   input  logic [11:0] qual,
   input  logic [11:0] deleg,
   output logic        valid,
   output logic [3:0]  cause,
   output logic        delegated
);
   always_comb begin
      valid = |(qual & INT_MASK);
      cause = qual[MEI] ? 4'(MEI) : qual[MSI] ? 4'(MSI) : qual[MTI] ? 4'(MTI) :
              qual[SEI] ? 4'(SEI) : qual[SSI] ? 4'(SSI) : 4'(STI);
      delegated = valid & deleg[cause];
   end
endmodule

// File: rtl/int_scheduler.sv
// int_scheduler: interrupt qualify/priority/hold plus WFI stall-wake FSM; the WFI timeout counter
// exists only when WFI_TIMEOUT_EN is defined, otherwise TW traps WFI immediately
module int_scheduler
   import cvw_pkg::*;
#(
   parameter int WFI_TIMEOUT = 4096,
   parameter int CNT_W       = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StallW,
   input  logic        FlushW,
   input  logic [11:0] MIP_REGW,
   input  logic [11:0] MIE_REGW,
   input  logic [11:0] MIDELEG_REGW,
   input  logic        STATUS_MIE,
   input  logic        STATUS_SIE,
   input  logic        STATUS_TW,
   input  logic [1:0]  PrivilegeModeW,
   input  logic        wfiM,
   input  logic        InstrValidM,
   input  logic        CommittedM,
   input  logic        CommittedF,
   input  logic        TrapTakenM,
   output logic        IntReqM,
   output logic [3:0]  IntCauseM,
   output logic        IntDelegateM,
   output logic        WfiStallM,
   output logic        WfiTimeoutM
);
   logic [11:0] pend, qual;
   logic        mEn, sEn, encValid, encDeleg, wfiEnter, twActive, timeoutNext;
   logic [3:0]  encCause;
   wfistate_t   state, stateNext;
`ifdef WFI_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(WFI_TIMEOUT - 1);
   logic [CNT_W-1:0] cnt, cntNext;
`else
   logic unusedCfg;
   assign unusedCfg = ^{WFI_TIMEOUT, CNT_W};
`endif

   assign pend     = MIP_REGW & MIE_REGW;
   assign mEn      = (PrivilegeModeW != 2'b11) | STATUS_MIE;
   assign sEn      = (PrivilegeModeW == 2'b00) | ((PrivilegeModeW == 2'b01) & STATUS_SIE);
   assign qual     = pend & ((~MIDELEG_REGW & {12{mEn}}) | (MIDELEG_REGW & {12{sEn}}));
   assign wfiEnter = wfiM & InstrValidM & ~StallW & ~|pend;
   assign twActive = STATUS_TW & (PrivilegeModeW != 2'b11);

   int_prio_enc prio (
      .qual(qual), .deleg(MIDELEG_REGW), .valid(encValid), .cause(encCause), .delegated(encDeleg)
   );

   // A live request holds its cause until taken or until its own bit disqualifies; only then re-select
   always_ff @(posedge clk)
      if (reset) {IntReqM, IntCauseM, IntDelegateM} <= '0;
      else if (~StallW) begin
         if (CommittedM | CommittedF) IntReqM <= 1'b0;
         else if (IntReqM & ~TrapTakenM) IntReqM <= qual[IntCauseM];
         else {IntReqM, IntCauseM, IntDelegateM} <= {encValid, encCause, encDeleg};
      end

   always_ff @(posedge clk)
      if (reset) begin
         state       <= RUN;
         WfiTimeoutM <= 1'b0;
`ifdef WFI_TIMEOUT_EN
         cnt         <= '0;
`endif
      end else if (~StallW) begin
         state       <= stateNext;
         WfiTimeoutM <= timeoutNext;
`ifdef WFI_TIMEOUT_EN
         cnt         <= cntNext;
`endif
      end

   // Wake is checked before timeout so a coincident interrupt suppresses the TW trap
   always_comb begin
      stateNext   = state;
      timeoutNext = 1'b0;
`ifdef WFI_TIMEOUT_EN
      cntNext = (state == WFI & ~FlushW) ? cnt : '0;
      if (state == RUN) stateNext = wfiEnter ? WFI : RUN;
      else if (state != WFI | FlushW) stateNext = RUN;
      else if (|pend) begin
         stateNext = WAKE;
         cntNext   = '0;
      end else if (twActive & cnt == TO_LAST) begin
         stateNext   = RUN;
         cntNext     = '0;
         timeoutNext = 1'b1;
      end else if (twActive & cnt != '1) cntNext = cnt + CNT_W'(1);
`else
      if (state == RUN) begin
         stateNext   = (wfiEnter & ~twActive) ? WFI : RUN;
         timeoutNext = wfiEnter & twActive;
      end else if (state != WFI | FlushW) stateNext = RUN;
      else if (|pend) stateNext = WAKE;
`endif
   end

   always_comb WfiStallM = (state == WFI);
endmodule

// File: tb/tb_int_scheduler.sv
// tb_int_scheduler: directed stimulus with a per-cycle expectation queue checked by a negedge monitor
module tb_int_scheduler;
  logic        clk = 0, reset = 1, StallW = 0, FlushW = 0;
  logic [11:0] MIP_REGW = 0, MIE_REGW = 0, MIDELEG_REGW = 0;
  logic        STATUS_MIE = 0, STATUS_SIE = 0, STATUS_TW = 0;
  logic [1:0]  PrivilegeModeW = 2'b11;
  logic        wfiM = 0, InstrValidM = 0, CommittedM = 0, CommittedF = 0, TrapTakenM = 0;
  logic        IntReqM, IntDelegateM, WfiStallM, WfiTimeoutM;
  logic [3:0]  IntCauseM;
  typedef struct {
    string      name;
    logic       req;
    logic [3:0] cause;
    logic       deleg;
    logic       stall;
    logic       to;
    logic       all;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0, n_fail = 0;
  int_scheduler #(.WFI_TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
    .MIP_REGW(MIP_REGW), .MIE_REGW(MIE_REGW), .MIDELEG_REGW(MIDELEG_REGW),
    .STATUS_MIE(STATUS_MIE), .STATUS_SIE(STATUS_SIE), .STATUS_TW(STATUS_TW),
    .PrivilegeModeW(PrivilegeModeW), .wfiM(wfiM), .InstrValidM(InstrValidM),
    .CommittedM(CommittedM), .CommittedF(CommittedF), .TrapTakenM(TrapTakenM),
    .IntReqM(IntReqM), .IntCauseM(IntCauseM), .IntDelegateM(IntDelegateM),
    .WfiStallM(WfiStallM), .WfiTimeoutM(WfiTimeoutM)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic want(input string n, input logic r, input logic [3:0] c, input logic d,
                      input logic s, input logic t, input logic a);
    sb.push_back('{n, r, c, d, s, t, a});
  endtask
  always @(negedge clk)
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      n_checks++;
      if (IntReqM !== cur.req || WfiStallM !== cur.stall || WfiTimeoutM !== cur.to ||
          ((cur.req || cur.all) && (IntCauseM !== cur.cause || IntDelegateM !== cur.deleg))) begin
        n_fail++;
        $display("FAIL %s: got req=%b cause=%0d deleg=%b stall=%b to=%b, want req=%b cause=%0d deleg=%b stall=%b to=%b",
                 cur.name, IntReqM, IntCauseM, IntDelegateM, WfiStallM, WfiTimeoutM,
                 cur.req, cur.cause, cur.deleg, cur.stall, cur.to);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick; tick;
    want("reset", 0, 0, 0, 0, 0, 1); reset = 0;
    tick; want("idle", 0, 0, 0, 0, 0, 0);
    PrivilegeModeW = 2'b11; STATUS_MIE = 1; MIP_REGW = 12'h888; MIE_REGW = 12'h888;
    tick; want("m_mei", 1, 11, 0, 0, 0, 0);
    MIP_REGW = 0; MIE_REGW = 0;
    tick; want("m_drop", 0, 0, 0, 0, 0, 0);
    PrivilegeModeW = 2'b01; STATUS_SIE = 1; MIDELEG_REGW = 12'h222; MIP_REGW = 12'h020; MIE_REGW = 12'h020;
    tick; want("s_sti", 1, 5, 1, 0, 0, 0);
    PrivilegeModeW = 2'b11;
    tick; want("s_in_m_drop", 0, 0, 0, 0, 0, 0);
    tick; want("s_in_m", 0, 0, 0, 0, 0, 0);
    PrivilegeModeW = 2'b01;
    tick; want("hold_sti", 1, 5, 1, 0, 0, 0);
    MIP_REGW = 12'h820; MIE_REGW = 12'h820;
    tick; want("hold_1", 1, 5, 1, 0, 0, 0);
    tick; want("hold_2", 1, 5, 1, 0, 0, 0);
    TrapTakenM = 1;
    tick; want("trap_mei", 1, 11, 0, 0, 0, 0);
    TrapTakenM = 0; MIP_REGW = 0; MIE_REGW = 0;
    tick; want("trap_drop", 0, 0, 0, 0, 0, 0);
    PrivilegeModeW = 2'b11; MIDELEG_REGW = 0; MIP_REGW = 12'h080; MIE_REGW = 12'h080; CommittedF = 1;
    tick; want("cf_1", 0, 0, 0, 0, 0, 0);
    tick; want("cf_2", 0, 0, 0, 0, 0, 0);
    CommittedF = 0;
    tick; want("cf_release", 1, 7, 0, 0, 0, 0);
    CommittedM = 1;
    tick; want("cm_block", 0, 0, 0, 0, 0, 0);
    CommittedM = 0;
    tick; want("cm_release", 1, 7, 0, 0, 0, 0);
    MIP_REGW = 0; MIE_REGW = 0;
    tick; want("idle2", 0, 0, 0, 0, 0, 0);
    STATUS_MIE = 0; wfiM = 1; InstrValidM = 1;
    for (int i = 1; i <= 10; i++) begin
      tick; want($sformatf("wfi_%0d", i), 0, 0, 0, 1, 0, 0);
      wfiM = 0; InstrValidM = 0;
      if (i == 10) begin MIP_REGW = 12'h080; MIE_REGW = 12'h080; end
    end
    tick; want("wake", 0, 0, 0, 0, 0, 0);
    tick; want("wake_run", 0, 0, 0, 0, 0, 0);
    wfiM = 1; InstrValidM = 1;
    tick; want("wfi_nop", 0, 0, 0, 0, 0, 0);
    wfiM = 0; InstrValidM = 0; MIP_REGW = 0; MIE_REGW = 0;
    tick; want("idle3", 0, 0, 0, 0, 0, 0);
    PrivilegeModeW = 2'b00; STATUS_TW = 1; wfiM = 1; InstrValidM = 1;
`ifdef WFI_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      tick; want($sformatf("to_wait_%0d", i), 0, 0, 0, 1, 0, 0);
      wfiM = 0; InstrValidM = 0;
    end
    tick; want("to_pulse", 0, 0, 0, 0, 1, 0);
    tick; want("to_after", 0, 0, 0, 0, 0, 0);
    wfiM = 1; InstrValidM = 1;
    for (int i = 1; i <= 8; i++) begin
      tick; want($sformatf("wvt_wait_%0d", i), 0, 0, 0, 1, 0, 0);
      wfiM = 0; InstrValidM = 0;
      if (i == 8) begin MIP_REGW = 12'h080; MIE_REGW = 12'h080; end
    end
    tick; want("wake_vs_to", 1, 7, 0, 0, 0, 0);
    MIP_REGW = 0; MIE_REGW = 0;
    tick; want("wvt_after", 0, 0, 0, 0, 0, 0);
`else
    tick; want("to_pulse", 0, 0, 0, 0, 1, 0);
    wfiM = 0; InstrValidM = 0;
    tick; want("to_after", 0, 0, 0, 0, 0, 0);
`endif
    STATUS_TW = 0; wfiM = 1; InstrValidM = 1;
    tick; want("flush_wfi", 0, 0, 0, 1, 0, 0);
    wfiM = 0; InstrValidM = 0; FlushW = 1;
    tick; want("flush_run", 0, 0, 0, 0, 0, 0);
    FlushW = 0;
    tick; want("flush_stay", 0, 0, 0, 0, 0, 0);
    PrivilegeModeW = 2'b11; STATUS_MIE = 1; wfiM = 1; InstrValidM = 1;
    tick; want("stall_wfi", 0, 0, 0, 1, 0, 0);
    wfiM = 0; InstrValidM = 0; StallW = 1; MIP_REGW = 12'h080; MIE_REGW = 12'h080;
    tick; want("frozen_1", 0, 0, 0, 1, 0, 0);
    tick; want("frozen_2", 0, 0, 0, 1, 0, 0);
    StallW = 0;
    tick; want("unstall", 1, 7, 0, 0, 0, 0);
    MIP_REGW = 0; MIE_REGW = 0;
    tick; want("unstall_run", 0, 0, 0, 0, 0, 0);
    wfiM = 1; InstrValidM = 1;
    tick; want("rst_wfi", 0, 0, 0, 1, 0, 0);
    wfiM = 0; InstrValidM = 0; reset = 1;
    tick; want("rst_run", 0, 0, 0, 0, 0, 1);
    reset = 0;
    tick; want("final", 0, 0, 0, 0, 0, 0);
    tick; tick;
    if (n_checks < 12) begin
      n_fail++;
      $display("FAIL count: only %0d checks ran", n_checks);
    end
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL queue: %0d expectations never checked", sb.size());
    end
    if (n_fail != 0) $display("FAIL: %0d failures", n_fail);
    else $display("PASS");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
